alu_writeback: RTL

//   Downstream neighbour of the combinational ALU: captures ALU result and status flags
//   in a one-entry EX/WB pipeline latch, commits them to the register file and flag register
//   one cycle later, and serves two combinational operand read ports, with bypass from the

---
 rtl/alu_writeback.sv | 114 +++++++++++
 1 files changed

// File: rtl/alu_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : alu_writeback
//  Purpose  : One-entry EX/WB latch behind the ALU. It commits results to the
//             register file and flag register, serves two bypassed read ports,
//             and counts retired register writes.
//  Revision : 1.0  initial release
// ============================================================================
module alu_writeback #(
    parameter int W    = 8,
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG),
    parameter int CW   = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          ExValid,
    input  logic          ExWrEn,
    input  logic          ExFlagEn,
    input  logic [AW-1:0] ExWrAddr,
    input  logic [W-1:0]  ExData,
    input  logic          ExZero,
    input  logic          ExParity,
    input  logic          ExOdd,
    input  logic          Flush,
    input  logic [AW-1:0] RdAddrA,
    input  logic [AW-1:0] RdAddrB,
    output logic [W-1:0]  RdDatA,
    output logic [W-1:0]  RdDatB,
    output logic          ZeroFlag,
    output logic          ParityFlag,
    output logic          OddFlag,
    output logic          WbValid,
    output logic [CW-1:0] RetireCnt
);

    logic [W-1:0]  regs [NREG];
    logic          lat_valid;
    logic          lat_wr;
    logic          lat_flag_en;
    logic [AW-1:0] lat_addr;
    logic [W-1:0]  lat_data;
    logic          lat_zero;
    logic          lat_parity;
    logic          lat_odd;
    logic          zero_flag;
    logic          parity_flag;
    logic          odd_flag;
    logic [CW-1:0] retire_cnt;
    logic          commit_wr;
    logic          commit_flags;

    // The latch reloads on every edge, so an entry lives for exactly one cycle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            lat_valid   <= 1'b0;
            lat_wr      <= 1'b0;
            lat_flag_en <= 1'b0;
            lat_addr    <= '0;
            lat_data    <= '0;
            lat_zero    <= 1'b0;
            lat_parity  <= 1'b0;
            lat_odd     <= 1'b0;
        end else begin
            lat_valid   <= ExValid & ~Flush & (ExWrEn | ExFlagEn);
            lat_wr      <= ExWrEn;
            lat_flag_en <= ExFlagEn;
            lat_addr    <= ExWrAddr;
            lat_data    <= ExData;
            lat_zero    <= ExZero;
            lat_parity  <= ExParity;
            lat_odd     <= ExOdd;
        end
    end

    assign commit_wr    = lat_valid & lat_wr;
    assign commit_flags = lat_valid & lat_flag_en;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            retire_cnt <= '0;
        end else if (commit_wr) begin
            regs[lat_addr] <= lat_data;
            retire_cnt     <= retire_cnt + CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            zero_flag   <= 1'b0;
            parity_flag <= 1'b0;
            odd_flag    <= 1'b0;
        end else if (commit_flags) begin
            zero_flag   <= lat_zero;
            parity_flag <= lat_parity;
            odd_flag    <= lat_odd;
        end
    end

    // Bypass only from the latch, never from the live Ex* inputs.
    assign RdDatA = (commit_wr && (RdAddrA == lat_addr)) ? lat_data : regs[RdAddrA];
    assign RdDatB = (commit_wr && (RdAddrB == lat_addr)) ? lat_data : regs[RdAddrB];

    assign ZeroFlag   = zero_flag;
    assign ParityFlag = parity_flag;
    assign OddFlag    = odd_flag;
    assign WbValid    = lat_valid;
    assign RetireCnt  = retire_cnt;

endmodule
`default_nettype wire
